// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared definitions for the 5-stage pipeline hazard controller:
//   - FSM state encoding (RUN / DRAIN / HALTED)
//   - EX operand forwarding select encoding
//   - STOP opcode value
//   - register-match helper used by the forwarding comparators
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [5:0] OP_STOP = 6'h3F;

  // True when an opcode field decodes as STOP (for the main decoder side).
  function automatic logic is_stop_op(input logic [5:0] op);
    return (op == OP_STOP);
  endfunction

  // A producing stage matches an operand only if it writes a non-zero register.
  function automatic logic reg_match(input logic       we,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//   Bundle between the pipeline datapath (master) and the hazard controller
//   (slave).
//   master drives : id_rs, id_rt, id_uses_rs, id_uses_rt, id_stop,
//                   ex_rd, ex_regwrite, ex_mem2reg, ex_redirect,
//                   mem_rd, mem_regwrite, wb_rd, wb_regwrite
//   slave drives  : pc_we, if_id_we, if_id_flush, id_ex_flush,
//                   fwd_a, fwd_b, halted, stall_cnt[CNT_W]
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_ctrl_pkg::*;

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_stop;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_mem2reg;
  logic             ex_redirect;
  logic [4:0]       mem_rd;
  logic             mem_regwrite;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;

  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_stop,
           ex_rd, ex_regwrite, ex_mem2reg, ex_redirect,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    input  pc_we, if_id_we, if_id_flush, id_ex_flush,
           fwd_a, fwd_b, halted, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_stop,
           ex_rd, ex_regwrite, ex_mem2reg, ex_redirect,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    output pc_we, if_id_we, if_id_flush, id_ex_flush,
           fwd_a, fwd_b, halted, stall_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
//   Combinational forwarding select for one EX operand.
//   i_ex_reg        : source register of the operand held in ID/EX
//   i_mem_rd/_regwrite, i_wb_rd/_regwrite : producers in MEM and WB
//   o_fwd           : FWD_MEM, FWD_WB or FWD_RF (MEM wins on a double match)
// ---------------------------------------------------------------------------
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_ex_reg,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_regwrite,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_regwrite,
  output logic [1:0] o_fwd
);

  // Youngest producer (MEM) takes priority over WB.
  always_comb begin
    o_fwd = FWD_RF;
    if (reg_match(i_mem_regwrite, i_mem_rd, i_ex_reg)) begin
      o_fwd = FWD_MEM;
    end else if (reg_match(i_wb_regwrite, i_wb_rd, i_ex_reg)) begin
      o_fwd = FWD_WB;
    end else begin
      o_fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Sequencing controller for the IF/ID/EX/MEM/WB pipeline: PC and IF/ID
//   write enables, IF/ID and ID/EX flushes, EX forwarding selects, the STOP
//   drain/halt sequence and a saturating load-use stall counter.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   hz     : slave side of pipeline_hazard_ctrl_if (all pipeline signals)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  state_t           r_state;
  logic [DW-1:0]    r_drain_cnt;
  logic             r_halted;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [4:0]       r_ex_rs;
  logic [4:0]       r_ex_rt;

  logic             w_load_use;
  logic             w_count_stall;
  logic             w_stop_accept;
  logic             w_pc_we;
  logic             w_if_id_we;
  logic             w_if_id_flush;
  logic             w_id_ex_flush;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // Hazard detection and per-state pipeline control.
  always_comb begin
    w_load_use = hz.ex_mem2reg && hz.ex_regwrite && (hz.ex_rd != 5'd0) &&
                 ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                  (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));
    w_pc_we       = 1'b0;
    w_if_id_we    = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b1;
    w_count_stall = 1'b0;
    w_stop_accept = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (hz.ex_redirect) begin
          // Wrong-path instructions in IF/ID and ID are both squashed.
          w_pc_we       = 1'b1;
          w_if_id_we    = 1'b1;
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
          w_pc_we       = 1'b0;
          w_if_id_we    = 1'b0;
          w_id_ex_flush = 1'b1;
          w_count_stall = 1'b1;
        end else if (hz.id_stop) begin
          w_pc_we       = 1'b0;
          w_if_id_we    = 1'b0;
          w_id_ex_flush = 1'b1;
          w_stop_accept = 1'b1;
        end else begin
          w_pc_we       = 1'b1;
          w_if_id_we    = 1'b1;
          w_id_ex_flush = 1'b0;
        end
      end
      ST_DRAIN, ST_HALTED: begin
        // Front end frozen; only older instructions keep moving.
        w_pc_we       = 1'b0;
        w_if_id_we    = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b1;
      end
      default: begin
        w_pc_we       = 1'b0;
        w_if_id_we    = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b1;
      end
    endcase
  end

  // STOP sequencing FSM with drain counter and registered halted flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_stop_accept) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - DW'(1);
          end
        end
        ST_HALTED: begin
          r_halted <= 1'b1;
        end
        default: begin
          // Unreachable encoding: park safely with the front end frozen.
          r_state  <= ST_HALTED;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_count_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Shadow of the ID/EX source fields; a bubble carries register 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_rs <= 5'd0;
      r_ex_rt <= 5'd0;
    end else if (w_id_ex_flush) begin
      r_ex_rs <= 5'd0;
      r_ex_rt <= 5'd0;
    end else begin
      r_ex_rs <= hz.id_rs;
      r_ex_rt <= hz.id_rt;
    end
  end

  fwd_select u_fwd_a (
    .i_ex_reg      (r_ex_rs),
    .i_mem_rd      (hz.mem_rd),
    .i_mem_regwrite(hz.mem_regwrite),
    .i_wb_rd       (hz.wb_rd),
    .i_wb_regwrite (hz.wb_regwrite),
    .o_fwd         (w_fwd_a)
  );

  fwd_select u_fwd_b (
    .i_ex_reg      (r_ex_rt),
    .i_mem_rd      (hz.mem_rd),
    .i_mem_regwrite(hz.mem_regwrite),
    .i_wb_rd       (hz.wb_rd),
    .i_wb_regwrite (hz.wb_regwrite),
    .o_fwd         (w_fwd_b)
  );

  assign hz.pc_we       = w_pc_we;
  assign hz.if_id_we    = w_if_id_we;
  assign hz.if_id_flush = w_if_id_flush;
  assign hz.id_ex_flush = w_id_ex_flush;
  assign hz.fwd_a       = w_fwd_a;
  assign hz.fwd_b       = w_fwd_b;
  assign hz.halted      = r_halted;
  assign hz.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed scenarios followed by random cycles, every cycle compared with a
//   behavioural model that tracks "cycles since STOP was accepted", the stall
//   count as an integer and the source registers of the instruction in EX.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TB_CNT_W = 8;
  localparam int DRAIN    = 3;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) hz ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(TB_CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  int errors = 0;
  int checks = 0;

  // model state
  int         m_age = 0;   // 0: running, 1..DRAIN: draining, >DRAIN: halted
  int         m_cnt = 0;
  logic [4:0] m_ex_rs = 5'd0;
  logic [4:0] m_ex_rt = 5'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fwd_exp(input logic [4:0] r);
    if (hz.mem_regwrite && hz.mem_rd != 5'd0 && hz.mem_rd == r) return 2;
    if (hz.wb_regwrite && hz.wb_rd != 5'd0 && hz.wb_rd == r) return 1;
    return 0;
  endfunction

  task automatic clear_inputs();
    hz.id_rs = 5'd0;  hz.id_rt = 5'd0;  hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
    hz.id_stop = 1'b0; hz.ex_rd = 5'd0; hz.ex_regwrite = 1'b0; hz.ex_mem2reg = 1'b0;
    hz.ex_redirect = 1'b0; hz.mem_rd = 5'd0; hz.mem_regwrite = 1'b0;
    hz.wb_rd = 5'd0;  hz.wb_regwrite = 1'b0;
  endtask

  // Called at a falling edge with inputs applied; returns at the next falling edge.
  task automatic step();
    bit lu, running, stop_ok, cnt_ok;
    int e_pc, e_ifwe, e_iff, e_idf;
    #2;
    lu = hz.ex_mem2reg && hz.ex_regwrite && hz.ex_rd != 5'd0 &&
         ((hz.id_uses_rs && hz.id_rs == hz.ex_rd) || (hz.id_uses_rt && hz.id_rt == hz.ex_rd));
    running = (m_age == 0);
    stop_ok = 1'b0;
    cnt_ok  = 1'b0;
    if (!running)            begin e_pc = 0; e_ifwe = 0; e_iff = 0; e_idf = 1; end
    else if (hz.ex_redirect) begin e_pc = 1; e_ifwe = 1; e_iff = 1; e_idf = 1; end
    else if (lu)             begin e_pc = 0; e_ifwe = 0; e_iff = 0; e_idf = 1; cnt_ok = 1'b1; end
    else if (hz.id_stop)     begin e_pc = 0; e_ifwe = 0; e_iff = 0; e_idf = 1; stop_ok = 1'b1; end
    else                     begin e_pc = 1; e_ifwe = 1; e_iff = 0; e_idf = 0; end
    if (rst_n) begin
      chk("pc_we",       32'(hz.pc_we),       32'(e_pc));
      chk("if_id_we",    32'(hz.if_id_we),    32'(e_ifwe));
      chk("if_id_flush", 32'(hz.if_id_flush), 32'(e_iff));
      chk("id_ex_flush", 32'(hz.id_ex_flush), 32'(e_idf));
      chk("fwd_a",       32'(hz.fwd_a),       32'(fwd_exp(m_ex_rs)));
      chk("fwd_b",       32'(hz.fwd_b),       32'(fwd_exp(m_ex_rt)));
      chk("halted",      32'(hz.halted),      32'(m_age > DRAIN));
      chk("stall_cnt",   32'(hz.stall_cnt),   32'(m_cnt));
    end
    @(posedge clk);
    if (!rst_n) begin
      m_age = 0; m_cnt = 0; m_ex_rs = 5'd0; m_ex_rt = 5'd0;
    end else begin
      if (cnt_ok && m_cnt < CNT_MAX) m_cnt++;
      if (stop_ok) m_age = 1;
      else if (m_age > 0 && m_age <= DRAIN) m_age++;
      m_ex_rs = (e_idf != 0) ? 5'd0 : hz.id_rs;
      m_ex_rt = (e_idf != 0) ? 5'd0 : hz.id_rt;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    do_reset();

    // reset-state outputs
    step();
    chk("rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);

    // LW $1 ; ADD $2,$1,$3
    clear_inputs();
    hz.ex_rd = 5'd1; hz.ex_regwrite = 1'b1; hz.ex_mem2reg = 1'b1;
    hz.id_rs = 5'd1; hz.id_rt = 5'd3; hz.id_uses_rs = 1'b1; hz.id_uses_rt = 1'b1;
    #1 chk("lu_pc_we", 32'(hz.pc_we), 32'd0);
    step();
    chk("lu_cnt", 32'(hz.stall_cnt), 32'd1);
    clear_inputs();
    hz.id_rs = 5'd1; hz.id_rt = 5'd3; hz.id_uses_rs = 1'b1; hz.id_uses_rt = 1'b1;
    hz.mem_rd = 5'd1; hz.mem_regwrite = 1'b1;
    #1 chk("lu_release_pc_we", 32'(hz.pc_we), 32'd1);
    step();
    clear_inputs();
    hz.wb_rd = 5'd1; hz.wb_regwrite = 1'b1;
    #1 chk("lu_fwd_a", 32'(hz.fwd_a), 32'(FWD_WB));
    step();

    // ADD $1 ; SUB $4,$1,$1
    clear_inputs();
    hz.ex_rd = 5'd1; hz.ex_regwrite = 1'b1;
    hz.id_rs = 5'd1; hz.id_rt = 5'd1; hz.id_uses_rs = 1'b1; hz.id_uses_rt = 1'b1;
    step();
    clear_inputs();
    hz.mem_rd = 5'd1; hz.mem_regwrite = 1'b1; hz.wb_rd = 5'd1; hz.wb_regwrite = 1'b1;
    #1 chk("alu_fwd_a", 32'(hz.fwd_a), 32'(FWD_MEM));
    chk("alu_fwd_b", 32'(hz.fwd_b), 32'(FWD_MEM));
    step();

    // LW $0 ; ADD $2,$0,$0
    clear_inputs();
    hz.ex_rd = 5'd0; hz.ex_regwrite = 1'b1; hz.ex_mem2reg = 1'b1;
    hz.id_uses_rs = 1'b1; hz.id_uses_rt = 1'b1;
    step();
    chk("r0_cnt", 32'(hz.stall_cnt), 32'd1);
    clear_inputs();
    hz.mem_regwrite = 1'b1; hz.wb_regwrite = 1'b1;
    #1 chk("r0_fwd_a", 32'(hz.fwd_a), 32'(FWD_RF));
    step();

    // taken branch with STOP in ID the same cycle
    clear_inputs();
    hz.ex_redirect = 1'b1; hz.id_stop = 1'b1;
    step();
    clear_inputs();
    #1 chk("br_still_run", 32'(hz.pc_we), 32'd1);
    step();

    // three ADDs then STOP; redirect during drain is ignored
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      hz.ex_rd = 5'(i + 5); hz.ex_regwrite = 1'b1;
      step();
    end
    clear_inputs();
    hz.id_stop = 1'b1;
    step();
    for (int i = 0; i < DRAIN; i++) begin
      clear_inputs();
      hz.ex_redirect = 1'b1;
      step();
    end
    chk("drain_halted", 32'(hz.halted), 32'd1);
    clear_inputs();
    step();
    step();
    do_reset();
    chk("post_halt_rst", 32'(hz.halted), 32'd0);

    // reset in the middle of a drain
    clear_inputs();
    hz.id_stop = 1'b1;
    step();
    clear_inputs();
    step();
    do_reset();
    #1 chk("mid_drain_rst_pc_we", 32'(hz.pc_we), 32'd1);
    step();

    // saturation of the stall counter
    clear_inputs();
    hz.ex_rd = 5'd7; hz.ex_regwrite = 1'b1; hz.ex_mem2reg = 1'b1;
    hz.id_rt = 5'd7; hz.id_uses_rt = 1'b1;
    for (int i = 0; i < CNT_MAX + 5; i++) step();
    chk("sat_cnt", 32'(hz.stall_cnt), 32'(CNT_MAX));

    // random traffic
    for (int i = 0; i < 800; i++) begin
      hz.id_rs        = 5'($urandom_range(0, 3));
      hz.id_rt        = 5'($urandom_range(0, 3));
      hz.id_uses_rs   = 1'($urandom_range(0, 1));
      hz.id_uses_rt   = 1'($urandom_range(0, 1));
      hz.id_stop      = ($urandom_range(0, 19) == 0);
      hz.ex_rd        = 5'($urandom_range(0, 3));
      hz.ex_regwrite  = 1'($urandom_range(0, 1));
      hz.ex_mem2reg   = 1'($urandom_range(0, 1));
      hz.ex_redirect  = ($urandom_range(0, 7) == 0);
      hz.mem_rd       = 5'($urandom_range(0, 3));
      hz.mem_regwrite = 1'($urandom_range(0, 1));
      hz.wb_rd        = 5'($urandom_range(0, 3));
      hz.wb_regwrite  = 1'($urandom_range(0, 1));
      rst_n           = ($urandom_range(0, 39) != 0);
      step();
      rst_n = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
